// File: rtl/store_buffer.sv
// Speculative store buffer between MEM and dmem: in-order alloc, ROB commit by index,
// in-order drain of committed entries, and youngest-entry load forwarding.
module store_buffer #(
  parameter int unsigned SB_SIZE = 4,
  parameter int unsigned IDX_W   = $clog2(SB_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid_i,
  input  logic [31:0]      alloc_addr_i,
  input  logic [31:0]      alloc_data_i,
  input  logic [1:0]       alloc_size_i,
  output logic             alloc_ready_o,
  output logic [IDX_W-1:0] alloc_idx_o,
  input  logic             commit_valid_i,
  input  logic [IDX_W-1:0] commit_idx_i,
  input  logic             flush_i,
  input  logic             ld_valid_i,
  input  logic [31:0]      ld_addr_i,
  input  logic [3:0]       ld_be_i,
  output logic             ld_hit_o,
  output logic [31:0]      ld_data_o,
  output logic             ld_conflict_o,
  output logic             dmem_req_valid_o,
  output logic [31:0]      dmem_req_addr_o,
  output logic [31:0]      dmem_req_data_o,
  output logic [3:0]       dmem_req_be_o,
  input  logic             dmem_req_ready_i,
  output logic             empty_o
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {StFree, StPending, StCommitted} entry_st_e;

  entry_st_e   state_q [SB_SIZE];
  entry_st_e   state_d [SB_SIZE];
  logic [29:0] addr_q  [SB_SIZE];
  logic [29:0] addr_d  [SB_SIZE];
  logic [31:0] data_q  [SB_SIZE];
  logic [31:0] data_d  [SB_SIZE];
  logic [3:0]  be_q    [SB_SIZE];
  logic [3:0]  be_d    [SB_SIZE];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, n_rem;
  logic             alloc_fire, drain_fire;
  logic [3:0]       new_be;
  logic [31:0]      new_data;

  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr_i[1:0];

  assign alloc_ready_o    = (count_q != CNT_W'(SB_SIZE));
  assign alloc_idx_o      = tail_q;
  assign empty_o          = (count_q == '0);
  assign dmem_req_valid_o = (state_q[head_q] == StCommitted);
  assign dmem_req_addr_o  = {addr_q[head_q], 2'b00};
  assign dmem_req_data_o  = data_q[head_q];
  assign dmem_req_be_o    = be_q[head_q];

  assign alloc_fire = alloc_valid_i && alloc_ready_o && !flush_i;
  assign drain_fire = dmem_req_valid_o && dmem_req_ready_i;

  always_comb begin
    new_be   = 4'b1111;
    new_data = alloc_data_i;
    case (alloc_size_i)
      2'd0: begin
        new_be   = 4'b0001 << alloc_addr_i[1:0];
        new_data = {4{alloc_data_i[7:0]}};
      end
      2'd1: begin
        new_be   = alloc_addr_i[1] ? 4'b1100 : 4'b0011;
        new_data = {2{alloc_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    n_rem   = '0;
    // Commit is applied before flush so a same-cycle commit survives the flush.
    if (commit_valid_i && state_q[commit_idx_i] == StPending) begin
      state_d[commit_idx_i] = StCommitted;
    end
    if (drain_fire) begin
      state_d[head_q] = StFree;
      head_d          = head_q + IDX_W'(1);
    end
    if (flush_i) begin
      for (int i = 0; i < SB_SIZE; i++) begin
        if (state_d[i] == StPending) state_d[i] = StFree;
        if (state_d[i] == StCommitted) n_rem = n_rem + CNT_W'(1);
      end
      tail_d  = head_d + IDX_W'(n_rem);
      count_d = n_rem;
    end else begin
      if (alloc_fire) begin
        state_d[tail_q] = StPending;
        addr_d[tail_q]  = alloc_addr_i[31:2];
        data_d[tail_q]  = new_data;
        be_d[tail_q]    = new_be;
        tail_d          = tail_q + IDX_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(drain_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_SIZE; i++) begin
        state_q[i] <= StFree;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit_valid_i) begin
      assert (state_q[commit_idx_i] == StPending)
        else $error("store_buffer: commit of non-pending entry %0d", commit_idx_i);
    end
  end

  // Walk oldest to youngest so the last match found is the youngest.
  logic [IDX_W-1:0] scan_idx;
  logic             fwd_match;
  logic [3:0]       sel_be;
  logic [31:0]      sel_data, sel_mask;

  always_comb begin
    scan_idx  = head_q;
    fwd_match = 1'b0;
    sel_be    = '0;
    sel_data  = '0;
    for (int i = 0; i < SB_SIZE; i++) begin
      scan_idx = head_q + IDX_W'(i);
      if (state_q[scan_idx] != StFree && addr_q[scan_idx] == ld_addr_i[31:2] &&
          (be_q[scan_idx] & ld_be_i) != 4'b0000) begin
        fwd_match = 1'b1;
        sel_be    = be_q[scan_idx];
        sel_data  = data_q[scan_idx];
      end
    end
    for (int b = 0; b < 4; b++) sel_mask[8*b +: 8] = {8{sel_be[b]}};
    ld_hit_o      = ld_valid_i && fwd_match && ((sel_be & ld_be_i) == ld_be_i);
    ld_conflict_o = ld_valid_i && fwd_match && ((sel_be & ld_be_i) != ld_be_i);
    ld_data_o     = ld_hit_o ? (sel_data & sel_mask) : 32'h0;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain, full/backpressure, forwarding, flush, reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid_i = 1'b0;
  logic [31:0] alloc_addr_i = '0;
  logic [31:0] alloc_data_i = '0;
  logic [1:0]  alloc_size_i = '0;
  logic        alloc_ready_o;
  logic [1:0]  alloc_idx_o;
  logic        commit_valid_i = 1'b0;
  logic [1:0]  commit_idx_i = '0;
  logic        flush_i = 1'b0;
  logic        ld_valid_i = 1'b0;
  logic [31:0] ld_addr_i = '0;
  logic [3:0]  ld_be_i = '0;
  logic        ld_hit_o;
  logic [31:0] ld_data_o;
  logic        ld_conflict_o;
  logic        dmem_req_valid_o;
  logic [31:0] dmem_req_addr_o;
  logic [31:0] dmem_req_data_o;
  logic [3:0]  dmem_req_be_o;
  logic        dmem_req_ready_i = 1'b1;
  logic        empty_o;

  int n_checks = 0;
  int n_errors = 0;

  store_buffer #(.SB_SIZE(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i), .alloc_data_i(alloc_data_i),
    .alloc_size_i(alloc_size_i), .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .commit_valid_i(commit_valid_i), .commit_idx_i(commit_idx_i), .flush_i(flush_i),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_be_i(ld_be_i),
    .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_conflict_o(ld_conflict_o),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_addr_o(dmem_req_addr_o),
    .dmem_req_data_o(dmem_req_data_o), .dmem_req_be_o(dmem_req_be_o),
    .dmem_req_ready_i(dmem_req_ready_i), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s);
    alloc_valid_i = v;
    alloc_addr_i  = a;
    alloc_data_i  = d;
    alloc_size_i  = s;
  endtask

  task automatic set_ld(input logic v, input logic [31:0] a, input logic [3:0] be);
    ld_valid_i = v;
    ld_addr_i  = a;
    ld_be_i    = be;
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    set_ld(1'b1, 32'h0000_0600, 4'b1111);
    check({tag, "_ready"}, alloc_ready_o, 1);
    check({tag, "_idx"}, alloc_idx_o, 0);
    check({tag, "_dvalid"}, dmem_req_valid_o, 0);
    check({tag, "_hit"}, ld_hit_o, 0);
    check({tag, "_conf"}, ld_conflict_o, 0);
    check({tag, "_empty"}, empty_o, 1);
    set_ld(1'b0, 32'h0, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_reset_outs("rst");

    // 1: single word store drains the cycle after commit
    set_alloc(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2);
    #1 check("t1_idx", alloc_idx_o, 0);
    tick();
    set_alloc(1'b0, 32'h0, 32'h0, 2'd0);
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    #1 check("t1_pend_novalid", dmem_req_valid_o, 0);
    tick();
    commit_valid_i = 1'b0;
    #1;
    check("t1_dvalid", dmem_req_valid_o, 1);
    check("t1_daddr", dmem_req_addr_o, 32'h100);
    check("t1_ddata", dmem_req_data_o, 32'hDEAD_BEEF);
    check("t1_dbe", dmem_req_be_o, 4'b1111);
    tick();
    check("t1_empty", empty_o, 1);
    check("t1_dvalid_off", dmem_req_valid_o, 0);

    // 2: fill, then backpressure a drain (head=1 here)
    dmem_req_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_alloc(1'b1, 32'h400 + 32'(4 * k), 32'hA0 + 32'(k), 2'd2);
      #1 check($sformatf("t2_idx%0d", k), alloc_idx_o, 32'((k + 1) % 4));
      tick();
    end
    set_alloc(1'b0, 32'h0, 32'h0, 2'd0);
    check("t2_full", alloc_ready_o, 0);
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd1;
    tick();
    commit_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t2_hold_v%0d", c), dmem_req_valid_o, 1);
      check($sformatf("t2_hold_a%0d", c), dmem_req_addr_o, 32'h400);
      check($sformatf("t2_hold_d%0d", c), dmem_req_data_o, 32'hA0);
      tick();
    end
    dmem_req_ready_i = 1'b1;
    #1 check("t2_no_bypass", alloc_ready_o, 0);
    tick();
    check("t2_ready_back", alloc_ready_o, 1);
    check("t2_next_pending", dmem_req_valid_o, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t2_flush_empty", empty_o, 1);

    // 3: byte store, partial vs covered loads
    set_alloc(1'b1, 32'h203, 32'h0000_00AB, 2'd0);
    tick();
    set_alloc(1'b0, 32'h0, 32'h0, 2'd0);
    set_ld(1'b1, 32'h200, 4'b1111);
    check("t3_word_conf", ld_conflict_o, 1);
    check("t3_word_nohit", ld_hit_o, 0);
    set_ld(1'b1, 32'h203, 4'b1000);
    check("t3_byte_hit", ld_hit_o, 1);
    check("t3_byte_data", ld_data_o, 32'hAB00_0000);
    check("t3_byte_noconf", ld_conflict_o, 0);
    set_ld(1'b1, 32'h200, 4'b0001);
    check("t3_disjoint_hit", ld_hit_o, 0);
    check("t3_disjoint_conf", ld_conflict_o, 0);
    set_ld(1'b1, 32'h204, 4'b1111);
    check("t3_other_word", ld_hit_o | ld_conflict_o, 0);
    set_ld(1'b0, 32'h0, 4'b0000);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;

    // 4: youngest match wins, no merging
    set_alloc(1'b1, 32'h300, 32'h1111_1111, 2'd2);
    tick();
    set_alloc(1'b1, 32'h300, 32'h2222_2222, 2'd2);
    tick();
    set_alloc(1'b0, 32'h0, 32'h0, 2'd0);
    set_ld(1'b1, 32'h300, 4'b1111);
    check("t4_hit", ld_hit_o, 1);
    check("t4_data", ld_data_o, 32'h2222_2222);
    set_ld(1'b0, 32'h0, 4'b0000);
    set_alloc(1'b1, 32'h302, 32'h5555_1234, 2'd1);
    tick();
    set_alloc(1'b0, 32'h0, 32'h0, 2'd0);
    set_ld(1'b1, 32'h300, 4'b1100);
    check("t4_half_hit", ld_hit_o, 1);
    check("t4_half_data", ld_data_o, 32'h1234_0000);
    set_ld(1'b1, 32'h300, 4'b1111);
    check("t4_nomerge_conf", ld_conflict_o, 1);
    set_ld(1'b0, 32'h0, 4'b0000);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;

    // 5: commit + flush in the same cycle keeps the committed entry
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dmem_req_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_alloc(1'b1, 32'h500 + 32'(4 * k), 32'h5 + 32'(k), 2'd2);
      tick();
    end
    set_alloc(1'b0, 32'h0, 32'h0, 2'd0);
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd0;
    tick();
    commit_idx_i = 2'd1;
    flush_i      = 1'b1;
    tick();
    commit_valid_i = 1'b0;
    flush_i        = 1'b0;
    #1;
    check("t5_tail", alloc_idx_o, 2);
    check("t5_d0_addr", dmem_req_addr_o, 32'h500);
    dmem_req_ready_i = 1'b1;
    tick();
    check("t5_d1_valid", dmem_req_valid_o, 1);
    check("t5_d1_addr", dmem_req_addr_o, 32'h504);
    check("t5_d1_data", dmem_req_data_o, 32'h6);
    tick();
    check("t5_empty", empty_o, 1);
    check("t5_idle", dmem_req_valid_o, 0);
    set_alloc(1'b1, 32'h700, 32'h7, 2'd2);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_alloc(1'b0, 32'h0, 32'h0, 2'd0);
    check("t5_af_idx", alloc_idx_o, 2);
    check("t5_af_empty", empty_o, 1);

    // 6: reset while a drain is pending
    dmem_req_ready_i = 1'b0;
    set_alloc(1'b1, 32'h600, 32'h60, 2'd2);
    tick();
    set_alloc(1'b1, 32'h604, 32'h61, 2'd2);
    commit_valid_i = 1'b1;
    commit_idx_i   = 2'd2;
    tick();
    set_alloc(1'b1, 32'h608, 32'h62, 2'd2);
    commit_idx_i = 2'd3;
    tick();
    set_alloc(1'b0, 32'h0, 32'h0, 2'd0);
    commit_idx_i = 2'd0;
    tick();
    commit_valid_i = 1'b0;
    check("t6_dvalid", dmem_req_valid_o, 1);
    check("t6_daddr", dmem_req_addr_o, 32'h600);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_reset_outs("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
